// File: rtl/vx_wb_pkg.sv
// Writeback packet type shared by the writeback arbiter and the commit stage.
// WB_IDX_BITS gives a source-index width that is never narrower than one bit.
package vx_wb_pkg;

    localparam int unsigned UUID_BITS   = 44;
    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned NW_BITS     = 2;
    localparam int unsigned NR_BITS     = 5;

    typedef struct packed {
        logic [UUID_BITS-1:0]          uuid;
        logic [NUM_THREADS-1:0]        tmask;
        logic [NW_BITS-1:0]            wid;
        logic [31:0]                   PC;
        logic [NR_BITS-1:0]            rd;
        logic [NUM_THREADS-1:0][31:0]  data;
        logic                          eop;
    } wb_packet_t;

    function automatic int unsigned WB_IDX_BITS(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_rr_picker.sv
// Combinational round-robin picker: the first valid source at or after ptr,
// searching upward and wrapping from NUM_REQS-1 back to 0.
module vx_rr_picker
    import vx_wb_pkg::*;
#(
    parameter  int unsigned NUM_REQS = 4,
    localparam int unsigned REQ_BITS = WB_IDX_BITS(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] valid,
    input  logic [REQ_BITS-1:0] ptr,
    output logic [NUM_REQS-1:0] grant,
    output logic [REQ_BITS-1:0] grant_idx,
    output logic                grant_valid
);

    // Wrap explicitly so a non-power-of-two NUM_REQS never visits an unused index.
    function automatic logic [REQ_BITS-1:0] wrap_idx(input logic [REQ_BITS-1:0] base,
                                                     input int unsigned ofs);
        int unsigned s;
        s = 32'(base) + ofs;
        if (s >= NUM_REQS) begin
            s = s - NUM_REQS;
        end
        return REQ_BITS'(s);
    endfunction

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (!grant_valid && valid[wrap_idx(ptr, i)]) begin
                grant[wrap_idx(ptr, i)] = 1'b1;
                grant_idx               = wrap_idx(ptr, i);
                grant_valid             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_writeback_arbiter.sv
// Round-robin arbiter sharing the register-file writeback port among NUM_REQS sources,
// with a one-slot registered output. Define VX_WB_ARB_PKT_LOCK_EN to keep multi-beat packets whole.
module vx_writeback_arbiter
    import vx_wb_pkg::*;
#(
    parameter  int unsigned NUM_REQS = 4,
    localparam int unsigned REQ_BITS = WB_IDX_BITS(NUM_REQS)
) (
    input  logic                                      clk,
    input  logic                                      reset,

    input  logic [NUM_REQS-1:0]                       req_valid,
    input  logic [NUM_REQS-1:0][UUID_BITS-1:0]        req_uuid,
    input  logic [NUM_REQS-1:0][NUM_THREADS-1:0]      req_tmask,
    input  logic [NUM_REQS-1:0][NW_BITS-1:0]          req_wid,
    input  logic [NUM_REQS-1:0][31:0]                 req_PC,
    input  logic [NUM_REQS-1:0][NR_BITS-1:0]          req_rd,
    input  logic [NUM_REQS-1:0][NUM_THREADS-1:0][31:0] req_data,
    input  logic [NUM_REQS-1:0]                       req_eop,
    output logic [NUM_REQS-1:0]                       req_ready,

    output logic                                      wb_valid,
    output logic [UUID_BITS-1:0]                      wb_uuid,
    output logic [NUM_THREADS-1:0]                    wb_tmask,
    output logic [NW_BITS-1:0]                        wb_wid,
    output logic [31:0]                               wb_PC,
    output logic [NR_BITS-1:0]                        wb_rd,
    output logic [NUM_THREADS-1:0][31:0]              wb_data,
    output logic                                      wb_eop,
    input  logic                                      wb_ready,

    output logic [REQ_BITS-1:0]                       grant_idx
);

    wb_packet_t          slot_q, slot_d;
    logic                valid_q, valid_d;
    logic [REQ_BITS-1:0] idx_q, idx_d;
    logic [REQ_BITS-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_REQS-1:0] eligible;
    logic [NUM_REQS-1:0] pick_grant;
    logic [REQ_BITS-1:0] pick_idx;
    logic                pick_valid;
    logic                slot_free;
    logic                xfer;
    wb_packet_t          sel_pkt;

    function automatic logic [REQ_BITS-1:0] ptr_after(input logic [REQ_BITS-1:0] k);
        return (k == REQ_BITS'(NUM_REQS - 1)) ? '0 : k + REQ_BITS'(1);
    endfunction

`ifdef VX_WB_ARB_PKT_LOCK_EN
    logic                locked_q, locked_d;
    logic [REQ_BITS-1:0] lock_idx_q, lock_idx_d;
    logic [NUM_REQS-1:0] lock_mask;

    assign lock_mask = NUM_REQS'(1) << lock_idx_q;

    // While a packet is open only its owner competes; idle owner beats stall everyone.
    always_comb begin
        eligible = req_valid;
        if (locked_q) begin
            eligible = req_valid & lock_mask;
        end
    end

    always_comb begin
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (xfer) begin
            if (!sel_pkt.eop) begin
                locked_d   = 1'b1;
                lock_idx_d = pick_idx;
            end else begin
                locked_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    a_lock_exclusive: assert property (@(posedge clk) disable iff (reset)
        locked_q |-> ((req_ready & ~lock_mask) == '0));
`else
    always_comb begin
        eligible = req_valid;
    end
`endif

    vx_rr_picker #(
        .NUM_REQS (NUM_REQS)
    ) u_picker (
        .valid       (eligible),
        .ptr         (rr_ptr_q),
        .grant       (pick_grant),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    assign slot_free = !valid_q || wb_ready;
    assign xfer      = slot_free && pick_valid && !reset;
    assign req_ready = xfer ? pick_grant : '0;

    always_comb begin
        sel_pkt       = '0;
        sel_pkt.uuid  = req_uuid[pick_idx];
        sel_pkt.tmask = req_tmask[pick_idx];
        sel_pkt.wid   = req_wid[pick_idx];
        sel_pkt.PC    = req_PC[pick_idx];
        sel_pkt.rd    = req_rd[pick_idx];
        sel_pkt.data  = req_data[pick_idx];
        sel_pkt.eop   = req_eop[pick_idx];
    end

    // A fire and a new grant in the same cycle reload the slot without a bubble.
    always_comb begin
        valid_d  = valid_q;
        slot_d   = slot_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        if (slot_free) begin
            valid_d = xfer;
            if (xfer) begin
                slot_d   = sel_pkt;
                idx_d    = pick_idx;
                rr_ptr_d = ptr_after(pick_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            slot_q   <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            slot_q   <= slot_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign wb_valid  = valid_q;
    assign wb_uuid   = slot_q.uuid;
    assign wb_tmask  = slot_q.tmask;
    assign wb_wid    = slot_q.wid;
    assign wb_PC     = slot_q.PC;
    assign wb_rd     = slot_q.rd;
    assign wb_data   = slot_q.data;
    assign wb_eop    = slot_q.eop;
    assign grant_idx = idx_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_ready));

    a_ready_valid: assert property (@(posedge clk) disable iff (reset)
        (req_ready & ~req_valid) == '0);

    a_ptr_range: assert property (@(posedge clk) disable iff (reset)
        32'(rr_ptr_q) < NUM_REQS);

    a_hold: assert property (@(posedge clk) disable iff (reset)
        (valid_q && !wb_ready) |=> (valid_q && $stable(slot_q) && $stable(idx_q)));

endmodule
